// File: rtl/gray_rx5.sv
// gray_rx5: synchronizes a Gray bus, decodes it to binary and flags illegal steps.
// Define GRAY_RX_STEP_CNT_EN to build the legal-step counter on step_cnt.
module gray_rx5 #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             dir_up,
    output logic             step_err,
    output logic [15:0]      step_cnt
);

    localparam int FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {INIT, TRACK} state_e;

    state_e           state_q, state_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] g_s, g_bin, diff;
    logic [WIDTH-1:0] g_prev_q, g_prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             fill_done, first_load, changed, one_hot;
    logic             step_ok, step_bad, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= g_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        g_bin = '0;
        for (int i = 0; i < WIDTH; i++) g_bin[i] = ^(g_s >> i);
    end

    assign diff       = g_s ^ g_prev_q;
    assign changed    = (diff != '0);
    assign one_hot    = ((diff & (diff - WIDTH'(1))) == '0);
    assign fill_done  = (fill_q == FW'(SYNC_STAGES));
    assign first_load = (state_q == INIT) && fill_done;
    assign step_ok    = (state_q == TRACK) && changed && one_hot;
    assign step_bad   = (state_q == TRACK) && changed && !one_hot;
    assign load       = first_load || step_ok || step_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            fill_q   <= '0;
            g_prev_q <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            g_prev_q <= g_prev_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        unique case (state_q)
            INIT: begin
                if (fill_done) state_d = TRACK;
                else           fill_d  = fill_q + FW'(1);
            end
            TRACK: state_d = TRACK;
        endcase
    end

    always_comb begin
        g_prev_d = load ? g_s   : g_prev_q;
        bin_d    = load ? g_bin : bin_q;
        valid_d  = load;
        dir_d    = dir_q;
        if (first_load)   dir_d = 1'b0;
        else if (step_ok) dir_d = (g_bin == bin_q + WIDTH'(1));
        // A fresh multi-bit error outranks a clear in the same cycle.
        err_d = err_q;
        if (step_bad)     err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

`ifdef GRAY_RX_STEP_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= 16'h0000;
        else if (step_ok) cnt_q <= cnt_q + 16'd1;
    end

    assign step_cnt = cnt_q;
`else
    assign step_cnt = 16'h0000;
`endif

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign dir_up    = dir_q;
    assign step_err  = err_q;

endmodule

// File: tb/tb_gray_rx5.sv
// tb_gray_rx5: directed vector bench for the Gray bus receiver.
// Expected step_cnt follows GRAY_RX_STEP_CNT_EN, as the design does.
module tb_gray_rx5;

    localparam int W  = 5;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  g_in = 5'b00010;
    logic          err_clr = 1'b0;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          dir_up;
    logic          step_err;
    logic [15:0]   step_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_rx5 #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .g_in     (g_in),
        .err_clr  (err_clr),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .dir_up   (dir_up),
        .step_err (step_err),
        .step_cnt (step_cnt)
    );

    typedef struct {
        logic [4:0]  g;
        logic        clr;
        logic        valid;
        logic [4:0]  bin;
        logic        dir;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ecnt(input logic [15:0] c);
`ifdef GRAY_RX_STEP_CNT_EN
        return c;
`else
        return 16'h0000 & c;
`endif
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bin_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] b,
                           input logic d, input logic e,
                           input logic [15:0] c);
        chk({tag, " bin_out"},  32'(bin_out),  32'(b));
        chk({tag, " dir_up"},   32'(dir_up),   32'(d));
        chk({tag, " step_err"}, 32'(step_err), 32'(e));
        chk({tag, " step_cnt"}, 32'(step_cnt), 32'(ecnt(c)));
    endtask

    initial begin
        int lat;
        int nv;

        vecs[0]  = '{5'b00110, 1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 16'd1};
        vecs[1]  = '{5'b00010, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 16'd2};
        vecs[2]  = '{5'b00101, 1'b0, 1'b1, 5'd6,  1'b0, 1'b1, 16'd2};
        vecs[3]  = '{5'b00101, 1'b1, 1'b0, 5'd6,  1'b0, 1'b0, 16'd2};
        vecs[4]  = '{5'b10001, 1'b1, 1'b1, 5'd30, 1'b0, 1'b1, 16'd2};
        vecs[5]  = '{5'b10001, 1'b1, 1'b0, 5'd30, 1'b0, 1'b0, 16'd2};
        vecs[6]  = '{5'b10000, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0, 16'd3};
        vecs[7]  = '{5'b00000, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 16'd4};
        vecs[8]  = '{5'b10000, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 16'd5};
        vecs[9]  = '{5'b00000, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 16'd6};
        vecs[10] = '{5'b00011, 1'b0, 1'b1, 5'd2,  1'b1, 1'b1, 16'd6};
        vecs[11] = '{5'b00011, 1'b1, 1'b0, 5'd2,  1'b1, 1'b0, 16'd6};

        // Reset values, then the initial load of Gray 00010 (3).
        @(negedge clk);
        chk("rst bin_valid", 32'(bin_valid), 32'd0);
        chk_out("rst", 5'd0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        wait_valid(lat);
        chk("init latency", 32'(lat), 32'(SS + 1));
        chk_out("init", 5'd3, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        chk("init single pulse", 32'(bin_valid), 32'd0);

        for (int v = 0; v < 12; v++) begin
            g_in    = vecs[v].g;
            err_clr = vecs[v].clr;
            if (vecs[v].valid) begin
                wait_valid(lat);
                err_clr = 1'b0;
                chk($sformatf("v%0d latency", v), 32'(lat), 32'(SS + 1));
                chk_out($sformatf("v%0d", v), vecs[v].bin, vecs[v].dir,
                        vecs[v].err, vecs[v].cnt);
                @(negedge clk);
                chk($sformatf("v%0d single pulse", v), 32'(bin_valid), 32'd0);
            end else begin
                nv = 0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (bin_valid) nv++;
                end
                err_clr = 1'b0;
                chk($sformatf("v%0d no pulse", v), 32'(nv), 32'd0);
                chk_out($sformatf("v%0d", v), vecs[v].bin, vecs[v].dir,
                        vecs[v].err, vecs[v].cnt);
            end
        end

        // Reset asserted between edges while a step is in flight.
        g_in = 5'b00001;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst bin_valid", 32'(bin_valid), 32'd0);
        chk_out("midrst", 5'd0, 1'b0, 1'b0, 16'd0);
        g_in = 5'b00111;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(lat);
        chk("reload latency", 32'(lat), 32'(SS + 1));
        chk_out("reload", 5'd5, 1'b0, 1'b0, 16'd0);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bin_valid) nv++;
        end
        chk("reload no extra pulse", 32'(nv), 32'd0);
        chk("reload step_err", 32'(step_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
